// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Operand fetch stage sitting directly in front of the ALU. Holds the
//   architectural register file plus a per-register pending-write scoreboard,
//   reads both source operands with write-back bypass, muxes the immediate
//   onto B, and hands aluOP/A/B to the ALU through a valid/ready register.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of the output slot and the scoreboard
//   in_*              decoded instruction (valid/ready handshake)
//   wb_*              write-back port into the register file
//   out_valid/ready   output handshake toward the ALU
//   aluOP, A, B       ALU operands
//   out_rd/regWrite   destination info travelling with the instruction
module operand_fetch_stage #(
  parameter int DATA_W = 65,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_aluOP,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_useImm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_regWrite,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        aluOP,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_regWrite
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0]             pend_q, pend_d;

  logic              vld_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [ADDR_W-1:0] rd_q;
  logic              rw_q;

  // Write-back hits on each field; r0 never bypasses.
  logic byp1, byp2, bypd;
  logic haz1, haz2, hazw, hazard, accept;
  logic [DATA_W-1:0] rs1_val, rs2_val, b_val;

  always_comb begin
    byp1 = wb_en && (wb_addr == in_rs1) && (in_rs1 != '0);
    byp2 = wb_en && (wb_addr == in_rs2) && (in_rs2 != '0);
    bypd = wb_en && (wb_addr == in_rd)  && (in_rd  != '0);

    rs1_val = '0;
    if (in_rs1 != '0) rs1_val = byp1 ? wb_data : regs_q[in_rs1];
    rs2_val = '0;
    if (in_rs2 != '0) rs2_val = byp2 ? wb_data : regs_q[in_rs2];
    b_val = in_useImm ? in_imm : rs2_val;

    // A write-back landing this cycle resolves the pending entry, so the
    // bypassed value is safe to consume.
    haz1   = pend_q[in_rs1] && (in_rs1 != '0) && !byp1;
    haz2   = !in_useImm && pend_q[in_rs2] && (in_rs2 != '0) && !byp2;
    hazw   = in_regWrite && (in_rd != '0) && pend_q[in_rd] && !bypd;
    hazard = haz1 || haz2 || hazw;

    in_ready = (!vld_q || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Scoreboard next state: clear first so a same-address set wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_en) pend_d[wb_addr] = 1'b0;
    if (accept && in_regWrite && (in_rd != '0)) pend_d[in_rd] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (wb_en && (wb_addr == ADDR_W'(i))) regs_q[i] <= wb_data;
      regs_q[0] <= '0;
      pend_q    <= pend_d;
    end
  end

  // Output slot: data fields only move on accept, so they hold under
  // backpressure and after the instruction drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      rw_q  <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      op_q  <= in_aluOP;
      a_q   <= rs1_val;
      b_q   <= b_val;
      rd_q  <= in_rd;
      rw_q  <= in_regWrite;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid    = vld_q;
  assign aluOP        = op_q;
  assign A            = a_q;
  assign B            = b_q;
  assign out_rd       = rd_q;
  assign out_regWrite = rw_q;

endmodule
